// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - register-file width constants and dump FSM states
package reg_dump_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - valid/ready stream carrying {address, data} words
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks the register file and streams each register out
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  reg_dump_if.master        out_if
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;

  // busy doubles as the datapath write-stall, so it must be glitch-free: registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            out_addr_q  <= idx_q;
            out_data_q  <= rd_data;
            out_valid_q <= 1'b1;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // abort wins over a same-cycle handshake; that word is treated as undelivered
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_addr          = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - self-checking bench for reg_dump
module tb_reg_dump;
  import reg_dump_pkg::*;

  localparam int NR  = 32;
  localparam int NR4 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, start4 = 1'b0, abort4 = 1'b0;
  logic [4:0]  rd_addr, rd_addr4;
  logic [31:0] rd_data, rd_data4;
  logic        busy, done, busy4, done4;
  logic [31:0] regs [NR];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit checking = 0;

  reg_dump_if bus ();
  reg_dump_if bus4 ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs[rd_addr4];

  reg_dump dut (
    .clock(clk), .reset(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .out_if(bus)
  );

  reg_dump #(.NUM_REGS(NR4)) dut4 (
    .clock(clk), .reset(rst), .start(start4), .abort(abort4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .busy(busy4), .done(done4),
    .out_if(bus4)
  );

  function automatic logic [31:0] preload(input int a);
    return 32'hA500_0000 + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: which word is owed to the sink and whether a dump is live
  bit m_active = 0, m_shown = 0, m_done = 0;
  int m_idx = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_shown = 0; m_done = 0; m_idx = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_shown = 0; m_idx = 0;
      end
    end else if (abort) begin
      m_active = 0; m_shown = 0;
    end else if (!m_shown) begin
      m_shown = 1;
    end else if (bus.out_ready) begin
      m_shown = 0;
      if (m_idx == NR - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_idx++;
      end
    end
  end

  int hs_cnt, done_cnt, done_cyc, busy_cnt;
  int vcyc [NR];
  int hs4, done4_cyc;
  int vcyc4 [NR4];

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, m_active);
      chk("out_valid", bus.out_valid, m_shown);
      chk("done", done, m_done);
      chk("rd_addr", rd_addr, m_idx);
      if (m_shown) begin
        chk("out_addr", bus.out_addr, m_idx);
        chk("out_data", bus.out_data, preload(m_idx));
      end
      if (bus.out_valid && bus.out_ready && !abort && !rst) hs_cnt++;
      if (bus.out_valid && vcyc[bus.out_addr] < 0) vcyc[bus.out_addr] = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (bus4.out_valid) begin
        chk("dut4_data", bus4.out_data, preload(int'(bus4.out_addr)));
        if (bus4.out_addr < NR4 && vcyc4[bus4.out_addr] < 0) vcyc4[bus4.out_addr] = cyc;
        if (bus4.out_ready && !rst) hs4++;
      end
      if (done4) done4_cyc = cyc;
    end
  end

  task automatic clear_stats();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    hs4 = 0; done4_cyc = -1;
    foreach (vcyc[i]) vcyc[i] = -1;
    foreach (vcyc4[i]) vcyc4[i] = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int k);
    k = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_word(input int a, input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.out_valid && bus.out_addr == 5'(a)) ok = 1;
      else step();
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (done) ok = 1;
      else step();
    end
    chk(name, ok, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, bus.out_addr, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    int k;
    bit ok;
    for (int i = 0; i < NR; i++) regs[i] = 32'hA500_0000 + 32'(i);
    bus.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    clear_stats();

    step();
    checking = 1;
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // full dump, ready held high
    clear_stats();
    pulse_start(k);
    wait_done("t1_wait_done");
    step();
    chk("t1_words", hs_cnt, 32);
    chk("t1_word0_cycle", vcyc[0], k + 2);
    chk("t1_word31_cycle", vcyc[31], k + 64);
    chk("t1_done_cycle", done_cyc, k + 65);
    chk("t1_busy_cycles", busy_cnt, 64);

    // back-to-back restart in the first IDLE cycle, then backpressure on word 7
    clear_stats();
    pulse_start(k);
    chk("t2_restart_busy", busy, 1);
    wait_word(7, "t2_wait_w7");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", bus.out_valid, 1);
      chk("t2_stall_addr", bus.out_addr, 7);
      chk("t2_stall_data", bus.out_data, 32'hA500_0007);
      step();
    end
    bus.out_ready = 1'b1;
    wait_done("t2_wait_done");
    step();
    chk("t2_words", hs_cnt, 32);
    chk("t2_word8_cycle", vcyc[8], k + 23);
    chk("t2_done_cycle", done_cyc, k + 70);
    chk("t2_done_count", done_cnt, 1);

    // abort coinciding with the handshake of word 10
    clear_stats();
    pulse_start(k);
    wait_word(10, "t3_wait_w10");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_valid", bus.out_valid, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t3_words", hs_cnt, 10);
    chk("t3_no_done", done_cnt, 0);

    // start during SEND is ignored
    clear_stats();
    pulse_start(k);
    wait_word(3, "t4_wait_w3");
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t4_wait_done");
    for (int i = 0; i < 6; i++) step();
    chk("t4_words", hs_cnt, 32);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_idle_busy", busy, 0);

    // reset during word 20, then a fresh dump from address 0
    clear_stats();
    pulse_start(k);
    wait_word(20, "t5_wait_w20");
    rst = 1'b1;
    step();
    chk_reset_outputs("t5_midreset");
    rst = 1'b0;
    step();
    clear_stats();
    pulse_start(k);
    wait_word(0, "t5_wait_w0");
    chk("t5_word0_cycle", cyc, k + 2);
    wait_done("t5_wait_done");
    step();
    chk("t5_words", hs_cnt, 32);

    // four-register instance
    clear_stats();
    k = cyc;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (done4) ok = 1;
      else step();
    end
    chk("t6_wait_done", ok, 1);
    step();
    chk("t6_words", hs4, 4);
    for (int i = 0; i < NR4; i++) chk("t6_word_cycle", vcyc4[i], k + 2 + 2 * i);
    chk("t6_done_cycle", done4_cyc, k + 9);
    chk("t6_busy", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the 32×32 register file. On a start request it drives the register file's read-address port, walks registers 0..NUM_REGS-1 in order, and streams each {address, data} pair out over a valid/ready handshake. While a dump is in progress it asserts a stall so the datapath holds register writes, giving a consistent snapshot. It sits beside the register file and uses one read port in place of the decode stage, selected by `busy`.

## Interface
- `NUM_REGS`, 32, number of registers walked; range 2..32.
- `ADDR_W`, 5, register address width; `NUM_REGS` ≤ 2^`ADDR_W`.
- `DATA_W`, 32, register data width.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `start`  in  1  request a dump; sampled only in IDLE.
- `abort`  in  1  cancel a dump in progress.
- `rd_addr`  out  ADDR_W  to register file read-address port.
- `rd_data`  in  DATA_W  from register file; combinational in `rd_addr`.
- `out_valid`  out  1  `out_addr`/`out_data` valid.
- `out_ready`  in  1  sink accepts the current word.
- `out_addr`  out  ADDR_W  register index of the current word.
- `out_data`  out  DATA_W  register contents of the current word.
- `busy`  out  1  dump in progress; also the write-stall/port-select to the datapath.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, SEND, DONE. Internal counter `idx` (ADDR_W bits).
- IDLE: `start`=1 and `abort`=0 -> `idx`←0, go to READ. Otherwise stay in IDLE.
- READ: `rd_addr`=`idx`. Capture `out_data`←`rd_data` and `out_addr`←`idx`, then go to SEND.
- SEND: `out_valid`=1. Handshake when `out_valid`&&`out_ready`.
  - On handshake with `idx`=NUM_REGS-1 -> DONE.
  - On handshake otherwise -> `idx`←`idx`+1, go to READ.
  - No handshake -> hold, with `out_addr`/`out_data` stable.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in READ and SEND; 0 in IDLE and DONE.
- `rd_addr`=`idx` in every state; it is 0 after reset.
- `abort`=1 in READ or SEND -> IDLE next edge. No `done`, no further words. `abort` takes priority over a same-cycle handshake; that word counts as not delivered. `abort` in IDLE/DONE: no effect, except `abort`=1 blocks `start` in IDLE.
- `start` in READ/SEND/DONE: ignored; it is not queued.
- `idx` never exceeds NUM_REGS-1; no wrap.
- Reset values: state IDLE, `idx`=0, `out_valid`=0, `busy`=0, `done`=0, `out_addr`=0, `out_data`=0, `rd_addr`=0.
- Reset mid-dump: same as reset; the sink sees `out_valid` drop with no handshake.

## Timing
- `start` sampled at edge k -> READ during cycle k+1 -> `out_valid`=1 with register 0 during cycle k+2.
- Each word takes a minimum of 2 cycles (READ + SEND). With `out_ready` held high, register i is valid in cycle k+2+2i.
- With NUM_REGS=32 and `out_ready` held high: `done` in cycle k+65, IDLE in cycle k+66, and `start` is accepted again at edge k+66.
- `out_valid` never deasserts without a handshake, except on `abort`/`reset`.
- `busy` rises in cycle k+1 and falls in the cycle `done` is high.

## Structure
- Shared package: state enum (IDLE/READ/SEND/DONE) and register-file width constants (ADDR_W=5, DATA_W=32, NUM_REGS=32), shared with the register file.
- Single module; no sub-module needed. The output holding register is inline.

## Test plan
- Preload reg i = 32'hA500_0000+i; pulse `start`, `out_ready`=1 -> 32 words, addresses 0..31 with matching data on cycles k+2+2i; `done` at k+65; `busy` high cycles k+1..k+64.
- Backpressure: `out_ready` low for 5 cycles on word 7 -> `out_valid`, `out_addr`=7, and `out_data` held stable for those 5 cycles; word 8 follows with no loss or duplication.
- `abort` on the same cycle as the handshake for word 10 -> IDLE next cycle, no `done`, word 10 not counted, `busy`=0.
- `start` pulsed during SEND of word 3 -> ignored; exactly one dump completes, with a single `done`.
- `reset` asserted during word 20 -> next cycle all outputs at reset values; a following `start` begins again from address 0.
- NUM_REGS=4 -> 4 words (0..3), `done` at k+9.
